mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter sitting directly downstream of the data load/store unit and the instruction prefetcher, merging their word-wide memory requests onto the single external memory bus. Data accesses have priority; a starvation counter guarantees instruction fetch progress. The grant is held for exactly one bus transaction per request, so a load/store unit issuing back-to-back halves of an unaligned access is re-arbitrated between halves.

## Interface
- STARVE_LIMIT, 4, consecutive data grants issued while an instruction request waits before instruction is forced to win (1..15)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- instr_m_addr  in  19  instruction word address [19:1]
- instr_m_access  in  1  instruction read request, held until ack
- instr_m_ack  out  1  instruction transaction complete
- instr_m_data_in  out  16  read data to prefetcher
- data_m_addr  in  19  data word address [19:1]
- data_m_data_out  in  16  write data
- data_m_wr_en  in  1  1 = write, 0 = read
- data_m_bytesel  in  2  byte enables {hi, lo}
- data_m_access  in  1  data request, held until ack
- data_m_ack  out  1  data transaction complete
- data_m_data_in  out  16  read data to load/store unit
- q_m_addr  out  19  external word address
- q_m_data_out  out  16  external write data
- q_m_wr_en  out  1  external write enable
- q_m_bytesel  out  2  external byte enables
- q_m_access  out  1  external request
- q_m_ack  in  1  external single-cycle completion pulse
- q_m_data_in  in  16  external read data

## Operation
- States: IDLE, GRANT_DATA, GRANT_INSTR (registered).
- IDLE: if data_m_access and not (instr_m_access and starve_cnt == STARVE_LIMIT) -> GRANT_DATA; else if instr_m_access -> GRANT_INSTR; else stay.
- GRANT_x: bus signals muxed combinationally from granted requester; instruction grant drives q_m_wr_en = 0, q_m_bytesel = 2'b11, q_m_data_out = 0.
- q_m_access = granted requester's access & ~q_m_ack; 0 in IDLE.
- q_m_ack routed combinationally to granted requester's ack only; other ack stays 0.
- q_m_data_in fanned out unregistered to both data_in outputs.
- GRANT_x -> IDLE on q_m_ack, or when granted requester drops access without ack (abort; q_m_access falls same cycle).
- starve_cnt (4 bits): on IDLE->GRANT_DATA with instr_m_access high, increments, saturating at STARVE_LIMIT; cleared on IDLE->GRANT_INSTR; unchanged otherwise.
- In IDLE q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel drive 0.
- q_m_ack while IDLE is ignored (no upstream ack).

## Timing
- Reset (async, reset_n low): state IDLE, starve_cnt 0; all outputs 0 immediately; reset mid-transaction drops q_m_access in the same instant.
- Request at cycle N with bus idle -> q_m_access at N+1 (one cycle arbitration).
- q_m_ack at cycle M -> requester ack at M (same cycle), state IDLE at M+1, earliest next q_m_access at M+2.
- Unaligned data access: second half request seen in IDLE at M+1; a waiting instruction request at starvation limit wins and is serviced between halves.
- Simultaneous data and instruction requests with starve_cnt < STARVE_LIMIT: data wins.
- Requesters hold addr/data/wr_en/bytesel stable while access is high; the arbiter does not latch them.

## Structure
- Package mem_arbiter_pkg: state enum (IDLE, GRANT_DATA, GRANT_INSTR), 4-bit starve counter width constant.
- Single flat module; no sub-module warranted.

## Test plan
- Reset: reset_n low with both requests high -> q_m_access, both acks, q_m_addr all 0; release -> q_m_access rises one cycle later for data.
- Lone instruction read at addr 19'h00100: q_m_access at N+1, q_m_ack at N+3 with data 16'hBEEF -> instr_m_ack pulse at N+3, instr_m_data_in 16'hBEEF, data_m_ack 0.
- Data write addr 19'h01234, data 16'h55AA, bytesel 2'b10 -> q bus carries exact values, q_m_wr_en 1, data_m_ack on q_m_ack.
- Both requesting continuously, STARVE_LIMIT 4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Data request dropped after grant before ack -> q_m_access falls same cycle, state IDLE next cycle, no ack issued.
- Async reset asserted during GRANT_DATA with q_m_access high -> q_m_access 0 without clock edge; starve_cnt cleared.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the two-port memory arbiter.
//   arb_state_e : arbiter FSM states
//   STARVE_W    : width of the instruction starvation counter
package mem_arbiter_pkg;
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_DATA  = 2'd1,
    GRANT_INSTR = 2'd2
  } arb_state_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the instruction port, the data port and the
// external memory bus of the arbiter.
//   slave  : arbiter view (takes requests, drives acks and the q_m bus)
//   master : requester/memory view (drives requests, q_m_ack, q_m_data_in)
interface mem_arbiter_if;
  logic [19:1] instr_m_addr;
  logic        instr_m_access;
  logic        instr_m_ack;
  logic [15:0] instr_m_data_in;

  logic [19:1] data_m_addr;
  logic [15:0] data_m_data_out;
  logic        data_m_wr_en;
  logic [1:0]  data_m_bytesel;
  logic        data_m_access;
  logic        data_m_ack;
  logic [15:0] data_m_data_in;

  logic [19:1] q_m_addr;
  logic [15:0] q_m_data_out;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_m_access;
  logic        q_m_ack;
  logic [15:0] q_m_data_in;

  modport slave (
    input  instr_m_addr, instr_m_access,
    output instr_m_ack, instr_m_data_in,
    input  data_m_addr, data_m_data_out, data_m_wr_en, data_m_bytesel, data_m_access,
    output data_m_ack, data_m_data_in,
    output q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel, q_m_access,
    input  q_m_ack, q_m_data_in
  );

  modport master (
    output instr_m_addr, instr_m_access,
    input  instr_m_ack, instr_m_data_in,
    output data_m_addr, data_m_data_out, data_m_wr_en, data_m_bytesel, data_m_access,
    input  data_m_ack, data_m_data_in,
    input  q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel, q_m_access,
    output q_m_ack, q_m_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: merges data (priority) and instruction memory requests onto
// one external bus. One bus transaction per grant; the FSM returns to IDLE
// after every ack so split accesses are re-arbitrated between halves.
// A starvation counter forces an instruction grant once STARVE_LIMIT data
// grants have been issued while an instruction request was waiting.
//   clk, reset_n : clock, async active-low reset
//   bus          : mem_arbiter_if.slave (requester ports + external bus)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIMIT);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (bus.data_m_access && !(bus.instr_m_access && starve_q == LIM)) begin
          state_d = GRANT_DATA;
          if (bus.instr_m_access && starve_q != LIM) starve_d = starve_q + 1'b1;
        end else if (bus.instr_m_access) begin
          state_d  = GRANT_INSTR;
          starve_d = '0;
        end
      end
      // Dropping access without an ack aborts the grant.
      GRANT_DATA:  if (bus.q_m_ack || !bus.data_m_access)  state_d = IDLE;
      GRANT_INSTR: if (bus.q_m_ack || !bus.instr_m_access) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Bus mux is combinational from the registered state; reset forces IDLE
  // asynchronously, which drops q_m_access at once.
  always_comb begin
    bus.q_m_addr     = '0;
    bus.q_m_data_out = '0;
    bus.q_m_wr_en    = 1'b0;
    bus.q_m_bytesel  = 2'b00;
    bus.q_m_access   = 1'b0;
    bus.instr_m_ack  = 1'b0;
    bus.data_m_ack   = 1'b0;
    case (state_q)
      GRANT_DATA: begin
        bus.q_m_addr     = bus.data_m_addr;
        bus.q_m_data_out = bus.data_m_data_out;
        bus.q_m_wr_en    = bus.data_m_wr_en;
        bus.q_m_bytesel  = bus.data_m_bytesel;
        bus.q_m_access   = bus.data_m_access & ~bus.q_m_ack;
        bus.data_m_ack   = bus.q_m_ack;
      end
      GRANT_INSTR: begin
        bus.q_m_addr     = bus.instr_m_addr;
        bus.q_m_bytesel  = 2'b11;
        bus.q_m_access   = bus.instr_m_access & ~bus.q_m_ack;
        bus.instr_m_ack  = bus.q_m_ack;
      end
      default: ;
    endcase
  end

  // Read data is shared by both requesters; held at 0 while in reset.
  assign bus.instr_m_data_in = reset_n ? bus.q_m_data_in : 16'h0000;
  assign bus.data_m_data_in  = reset_n ? bus.q_m_data_in : 16'h0000;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nclk();
    @(negedge clk);
  endtask

  // grant log: 1 = instruction, 0 = data
  logic [15:0] glog;
  int          g_n;
  logic [9:0]  exp_seq;

  initial begin
    bus.instr_m_addr    = 19'h0;
    bus.instr_m_access  = 1'b0;
    bus.data_m_addr     = 19'h0;
    bus.data_m_data_out = 16'h0;
    bus.data_m_wr_en    = 1'b0;
    bus.data_m_bytesel  = 2'b00;
    bus.data_m_access   = 1'b0;
    bus.q_m_ack         = 1'b0;
    bus.q_m_data_in     = 16'h0;

    // Reset with both requests pending
    bus.instr_m_addr   = 19'h00AAA;
    bus.data_m_addr    = 19'h00555;
    bus.instr_m_access = 1'b1;
    bus.data_m_access  = 1'b1;
    repeat (3) nclk();
    #1;
    chk("rst_access", bus.q_m_access, 0);
    chk("rst_dack",   bus.data_m_ack, 0);
    chk("rst_iack",   bus.instr_m_ack, 0);
    chk("rst_addr",   bus.q_m_addr, 0);
    nclk();
    reset_n = 1'b1;
    #1;
    chk("rel_access_n", bus.q_m_access, 0);
    nclk();
    #1;
    chk("rel_access_n1", bus.q_m_access, 1);
    chk("rel_addr_data", bus.q_m_addr, 19'h00555);
    bus.instr_m_access = 1'b0;
    bus.data_m_access  = 1'b0;
    #1;
    chk("rel_abort", bus.q_m_access, 0);
    nclk();
    // Clean starve count for the following tests
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    nclk();

    // Lone instruction read
    bus.instr_m_addr   = 19'h00100;
    bus.instr_m_access = 1'b1;
    #1;
    chk("i_access_n", bus.q_m_access, 0);
    nclk(); #1;
    chk("i_access_n1", bus.q_m_access, 1);
    chk("i_addr",      bus.q_m_addr, 19'h00100);
    chk("i_wr_en",     bus.q_m_wr_en, 0);
    chk("i_bytesel",   bus.q_m_bytesel, 2'b11);
    chk("i_dout",      bus.q_m_data_out, 0);
    nclk(); #1;
    chk("i_noack_n2", bus.instr_m_ack, 0);
    nclk();
    bus.q_m_ack     = 1'b1;
    bus.q_m_data_in = 16'hBEEF;
    #1;
    chk("i_ack",       bus.instr_m_ack, 1);
    chk("i_data",      bus.instr_m_data_in, 16'hBEEF);
    chk("i_dack_zero", bus.data_m_ack, 0);
    chk("i_access_ack", bus.q_m_access, 0);
    nclk();
    bus.q_m_ack        = 1'b0;
    bus.instr_m_access = 1'b0;
    #1;
    chk("i_ack_end", bus.instr_m_ack, 0);
    chk("i_idle",    bus.q_m_access, 0);
    nclk();

    // Data write, then held request re-granted, then abort
    bus.data_m_addr     = 19'h01234;
    bus.data_m_data_out = 16'h55AA;
    bus.data_m_wr_en    = 1'b1;
    bus.data_m_bytesel  = 2'b10;
    bus.data_m_access   = 1'b1;
    nclk(); #1;
    chk("d_access", bus.q_m_access, 1);
    chk("d_addr",   bus.q_m_addr, 19'h01234);
    chk("d_dout",   bus.q_m_data_out, 16'h55AA);
    chk("d_wr_en",  bus.q_m_wr_en, 1);
    chk("d_bytesel", bus.q_m_bytesel, 2'b10);
    bus.q_m_ack = 1'b1;
    #1;
    chk("d_ack",       bus.data_m_ack, 1);
    chk("d_iack_zero", bus.instr_m_ack, 0);
    nclk();
    bus.q_m_ack = 1'b0;
    #1;
    chk("d_idle_m1",   bus.q_m_access, 0);
    chk("d_idle_dout", bus.q_m_data_out, 0);
    chk("d_idle_wr",   bus.q_m_wr_en, 0);
    nclk(); #1;
    chk("d_regrant_m2", bus.q_m_access, 1);
    bus.data_m_access = 1'b0;
    #1;
    chk("abort_access", bus.q_m_access, 0);
    chk("abort_ack",    bus.data_m_ack, 0);
    nclk(); #1;
    chk("abort_idle", bus.q_m_access, 0);
    bus.q_m_ack = 1'b1;  // ack while idle must not reach a requester
    #1;
    chk("idle_ack_d", bus.data_m_ack, 0);
    chk("idle_ack_i", bus.instr_m_ack, 0);
    bus.q_m_ack = 1'b0;
    bus.data_m_wr_en = 1'b0;
    nclk();

    // Async reset mid data grant, with a nonzero starve count
    bus.data_m_addr    = 19'h00020;
    bus.instr_m_addr   = 19'h00040;
    bus.data_m_access  = 1'b1;
    bus.instr_m_access = 1'b1;
    nclk(); #1;
    chk("mr_access", bus.q_m_access, 1);
    chk("mr_data_first", bus.q_m_addr, 19'h00020);
    reset_n = 1'b0;
    #1;
    chk("mr_access_drop", bus.q_m_access, 0);
    chk("mr_starve_clr",  dut.starve_q, 0);
    nclk();
    reset_n = 1'b1;

    // Continuous contention: D,D,D,D,I,D,D,D,D,I
    glog = '0;
    g_n  = 0;
    for (int c = 0; c < 200 && g_n < 10; c++) begin
      nclk();
      if (bus.q_m_ack) bus.q_m_ack = 1'b0;
      else if (bus.q_m_access) begin
        bus.q_m_ack = 1'b1;
        #1;
        glog[g_n] = bus.instr_m_ack;
        g_n++;
      end
    end
    chk("seq_count", g_n, 10);
    exp_seq = 10'b10000_10000;
    for (int i = 0; i < 10; i++) chk($sformatf("seq_grant%0d", i), glog[i], exp_seq[i]);
    nclk();
    bus.q_m_ack        = 1'b0;
    bus.data_m_access  = 1'b0;
    bus.instr_m_access = 1'b0;
    nclk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
